// File: rtl/ristretto_mem_arbiter.sv
// Round-robin arbiter that funnels fetch, load and store requests onto a single
// memory channel, one outstanding transaction at a time, with a response timeout.
module ristretto_mem_arbiter #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    if_req_i,
  input  logic [AddressWidth-1:0] if_addr_i,
  output logic                    if_ready_o,
  output logic                    if_valid_o,

  input  logic                    ld_req_i,
  input  logic [AddressWidth-1:0] ld_addr_i,
  input  logic [DataWidth/8-1:0]  ld_strb_i,
  output logic                    ld_ready_o,
  output logic                    ld_valid_o,

  input  logic                    st_req_i,
  input  logic [AddressWidth-1:0] st_addr_i,
  input  logic [DataWidth/8-1:0]  st_strb_i,
  input  logic [DataWidth-1:0]    st_data_i,
  output logic                    st_ready_o,
  output logic                    st_valid_o,

  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic [1:0]              grant_o,
  output logic                    busy_o,

  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [DataWidth/8-1:0]  mem_strb_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_valid_i,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int StrbWidth = DataWidth / 8;
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

  localparam logic [1:0] OwnerFetch = 2'd0;
  localparam logic [1:0] OwnerLoad  = 2'd1;
  localparam logic [1:0] OwnerStore = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WRDY = 2'd1,
    WVLD = 2'd2
  } stateT;

  stateT                   state_q;
  logic [1:0]              grant_q;
  logic [1:0]              lastWinner_q;
  logic                    memReq_q;
  logic                    memWe_q;
  logic [AddressWidth-1:0] memAddr_q;
  logic [StrbWidth-1:0]    memStrb_q;
  logic [DataWidth-1:0]    memWdata_q;
  logic [15:0]             waitCnt_q;

  logic [2:0]              reqVec;
  logic                    anyReq;
  logic [1:0]              winner_d;
  logic [AddressWidth-1:0] addr_d;
  logic [StrbWidth-1:0]    strb_d;
  logic [DataWidth-1:0]    wdata_d;
  logic                    acceptHit;
  logic                    validHit;
  logic                    timeoutHit;

  // Picks the first requester found when scanning in the given priority order.
  function automatic logic [1:0] pickFirst(input logic [2:0] req,
                                           input logic [1:0] first,
                                           input logic [1:0] second,
                                           input logic [1:0] third);
    if (req[first])       return first;
    else if (req[second]) return second;
    else                  return third;
  endfunction

  assign reqVec = {st_req_i, ld_req_i, if_req_i};
  assign anyReq = |reqVec;

  always_comb begin
    winner_d = OwnerFetch;
    case (lastWinner_q)
      OwnerFetch: winner_d = pickFirst(reqVec, OwnerLoad, OwnerStore, OwnerFetch);
      OwnerLoad:  winner_d = pickFirst(reqVec, OwnerStore, OwnerFetch, OwnerLoad);
      default:    winner_d = pickFirst(reqVec, OwnerFetch, OwnerLoad, OwnerStore);
    endcase
  end

  always_comb begin
    addr_d  = if_addr_i;
    strb_d  = '1;
    wdata_d = '0;
    case (winner_d)
      OwnerLoad: begin
        addr_d = ld_addr_i;
        strb_d = ld_strb_i;
      end
      OwnerStore: begin
        addr_d  = st_addr_i;
        strb_d  = st_strb_i;
        wdata_d = st_data_i;
      end
      default: ;
    endcase
  end

  assign acceptHit  = (state_q == WRDY) && mem_ready_i;
  assign validHit   = (state_q == WVLD) && mem_valid_i;
  // The last wait cycle is the timeout cycle; a response arriving in it still wins.
  assign timeoutHit = (state_q == WVLD) && (waitCnt_q == TimeoutLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= OwnerFetch;
      lastWinner_q <= OwnerStore;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memStrb_q    <= '0;
      memWdata_q   <= '0;
      waitCnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            grant_q      <= winner_d;
            lastWinner_q <= winner_d;
            memReq_q     <= 1'b1;
            memWe_q      <= (winner_d == OwnerStore);
            memAddr_q    <= addr_d;
            memStrb_q    <= strb_d;
            memWdata_q   <= wdata_d;
            state_q      <= WRDY;
          end
        end
        WRDY: begin
          if (mem_ready_i) begin
            memReq_q  <= 1'b0;
            waitCnt_q <= '0;
            state_q   <= WVLD;
          end
        end
        WVLD: begin
          if (mem_valid_i || timeoutHit) begin
            state_q <= IDLE;
          end else begin
            waitCnt_q <= waitCnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ready_o = acceptHit && (grant_q == OwnerFetch);
  assign ld_ready_o = acceptHit && (grant_q == OwnerLoad);
  assign st_ready_o = acceptHit && (grant_q == OwnerStore);
  assign if_valid_o = validHit && (grant_q == OwnerFetch);
  assign ld_valid_o = validHit && (grant_q == OwnerLoad);
  assign st_valid_o = validHit && (grant_q == OwnerStore);

  assign err_o       = timeoutHit && !mem_valid_i;
  assign busy_o      = (state_q != IDLE);
  assign grant_o     = grant_q;
  assign rdata_o     = mem_rdata_i;
  assign mem_req_o   = memReq_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_strb_o  = memStrb_q;
  assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_ristretto_mem_arbiter.sv
// Directed self-checking bench for ristretto_mem_arbiter with a 4-cycle timeout.
module tb_ristretto_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i, ld_req_i, st_req_i;
  logic [AW-1:0] if_addr_i, ld_addr_i, st_addr_i;
  logic [DW/8-1:0] ld_strb_i, st_strb_i;
  logic [DW-1:0] st_data_i;
  logic          if_ready_o, if_valid_o, ld_ready_o, ld_valid_o, st_ready_o, st_valid_o;
  logic [DW-1:0] rdata_o;
  logic          err_o, busy_o;
  logic [1:0]    grant_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW/8-1:0] mem_strb_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ready_i, mem_valid_i;
  logic [DW-1:0] mem_rdata_i;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk_i = ~clk_i;

  ristretto_mem_arbiter #(
    .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_valid_o(if_valid_o),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_strb_i(ld_strb_i),
    .ld_ready_o(ld_ready_o), .ld_valid_o(ld_valid_o),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_strb_i(st_strb_i), .st_data_i(st_data_i),
    .st_ready_o(st_ready_o), .st_valid_o(st_valid_o),
    .rdata_o(rdata_o), .err_o(err_o), .grant_o(grant_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_strb_o(mem_strb_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i)
  );

  // Every comparison funnels through here so the totals stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic ldReq, input logic stReq);
    if_req_i = ifReq;
    ld_req_i = ldReq;
    st_req_i = stReq;
  endtask

  task automatic doReset();
    rst_i       = 1'b1;
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
  endtask

  // Runs one granted transaction: grant check, ready next cycle, valid the cycle after.
  task automatic serveOne(input logic [1:0] expGrant, input logic [AW-1:0] expAddr,
                          input logic [3:0] expStrb, input logic [DW-1:0] expWdata,
                          input string tag);
    logic [2:0] readyVec;
    logic [2:0] validVec;
    @(negedge clk_i);
    #1;
    checkOutput({tag, " grant"}, grant_o, expGrant);
    checkOutput({tag, " busy"}, busy_o, 1'b1);
    checkOutput({tag, " mem_req"}, mem_req_o, 1'b1);
    checkOutput({tag, " we"}, mem_we_o, (expGrant == 2'd2));
    checkOutput({tag, " addr"}, mem_addr_o, expAddr);
    checkOutput({tag, " strb"}, mem_strb_o, expStrb);
    checkOutput({tag, " wdata"}, mem_wdata_o, expWdata);
    mem_ready_i = 1'b1;
    #1;
    readyVec = {st_ready_o, ld_ready_o, if_ready_o};
    checkOutput({tag, " ready"}, readyVec, 64'd1 << expGrant);
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    case (expGrant)
      2'd0:    if_req_i = 1'b0;
      2'd1:    ld_req_i = 1'b0;
      default: st_req_i = 1'b0;
    endcase
    mem_valid_i = 1'b1;
    mem_rdata_i = 32'h1000 + 32'(expGrant);
    #1;
    validVec = {st_valid_o, ld_valid_o, if_valid_o};
    checkOutput({tag, " valid"}, validVec, 64'd1 << expGrant);
    checkOutput({tag, " rdata"}, rdata_o, 32'h1000 + 32'(expGrant));
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    #1;
    checkOutput({tag, " idle"}, busy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    if_addr_i   = '0;
    ld_addr_i   = '0;
    st_addr_i   = '0;
    ld_strb_i   = '0;
    st_strb_i   = '0;
    st_data_i   = '0;
    mem_rdata_i = '0;
    $display("[TB] reset checks");
    doReset();
    checkOutput("rst mem_req", mem_req_o, 1'b0);
    checkOutput("rst busy", busy_o, 1'b0);
    checkOutput("rst grant", grant_o, 2'd0);
    checkOutput("rst err", err_o, 1'b0);
    checkOutput("rst addr", mem_addr_o, 0);
    checkOutput("rst strb", mem_strb_o, 0);
    checkOutput("rst we", mem_we_o, 1'b0);

    $display("[TB] single fetch");
    @(negedge clk_i);
    if_addr_i = 32'h100;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    #1;
    checkOutput("fetch mem_req", mem_req_o, 1'b1);
    checkOutput("fetch addr", mem_addr_o, 32'h100);
    checkOutput("fetch strb", mem_strb_o, 4'hF);
    checkOutput("fetch we", mem_we_o, 1'b0);
    checkOutput("fetch early ready", if_ready_o, 1'b0);
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    #1;
    checkOutput("fetch ready", if_ready_o, 1'b1);
    checkOutput("fetch ld_ready", ld_ready_o, 1'b0);
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    if_req_i    = 1'b0;
    #1;
    checkOutput("fetch ready pulse", if_ready_o, 1'b0);
    checkOutput("fetch req cleared", mem_req_o, 1'b0);
    checkOutput("fetch early valid", if_valid_o, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem_rdata_i = 32'hCAFEF00D;
    #1;
    checkOutput("fetch valid", if_valid_o, 1'b1);
    checkOutput("fetch rdata", rdata_o, 32'hCAFEF00D);
    checkOutput("fetch no err", err_o, 1'b0);
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    #1;
    checkOutput("fetch valid pulse", if_valid_o, 1'b0);
    checkOutput("fetch idle", busy_o, 1'b0);

    $display("[TB] round-robin fetch/load");
    doReset();
    if_addr_i = 32'h180;
    ld_addr_i = 32'h200;
    ld_strb_i = 4'hC;
    applyStimulus(1'b1, 1'b1, 1'b0);
    serveOne(2'd0, 32'h180, 4'hF, 32'h0, "arb1");
    if_req_i = 1'b1;
    serveOne(2'd1, 32'h200, 4'hC, 32'h0, "arb2");
    ld_req_i = 1'b1;
    serveOne(2'd0, 32'h180, 4'hF, 32'h0, "arb3");
    serveOne(2'd1, 32'h200, 4'hC, 32'h0, "arb4");

    $display("[TB] store");
    st_addr_i = 32'h2004;
    st_data_i = 32'hDEADBEEF;
    st_strb_i = 4'h3;
    applyStimulus(1'b0, 1'b0, 1'b1);
    serveOne(2'd2, 32'h2004, 4'h3, 32'hDEADBEEF, "store");

    $display("[TB] timeout");
    if_addr_i = 32'h300;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    repeat (6) @(negedge clk_i);
    #1;
    checkOutput("wrdy holds busy", busy_o, 1'b1);
    checkOutput("wrdy holds req", mem_req_o, 1'b1);
    checkOutput("wrdy no err", err_o, 1'b0);
    mem_ready_i = 1'b1;
    #1;
    checkOutput("to ready", if_ready_o, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      if_req_i    = 1'b0;
      #1;
      checkOutput($sformatf("to wait%0d err", k), err_o, 1'b0);
    end
    @(negedge clk_i);
    #1;
    checkOutput("to err pulse", err_o, 1'b1);
    checkOutput("to no valid", if_valid_o, 1'b0);
    @(negedge clk_i);
    #1;
    checkOutput("to err cleared", err_o, 1'b0);
    checkOutput("to idle", busy_o, 1'b0);
    checkOutput("to mem_req", mem_req_o, 1'b0);

    $display("[TB] valid in timeout cycle");
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    if_req_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    mem_valid_i = 1'b1;
    #1;
    checkOutput("late valid wins", if_valid_o, 1'b1);
    checkOutput("late valid no err", err_o, 1'b0);
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    #1;
    checkOutput("late valid idle", busy_o, 1'b0);

    $display("[TB] reset mid-transaction");
    if_addr_i = 32'h400;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    if_req_i    = 1'b0;
    rst_i       = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("midrst busy", busy_o, 1'b0);
    checkOutput("midrst mem_req", mem_req_o, 1'b0);
    checkOutput("midrst addr", mem_addr_o, 0);
    checkOutput("midrst strb", mem_strb_o, 0);
    checkOutput("midrst grant", grant_o, 2'd0);
    mem_valid_i = 1'b1;
    #1;
    checkOutput("midrst stray valid", if_valid_o, 1'b0);
    checkOutput("midrst stray err", err_o, 1'b0);
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    if_addr_i   = 32'h500;
    applyStimulus(1'b1, 1'b1, 1'b0);
    serveOne(2'd0, 32'h500, 4'hF, 32'h0, "postrst");
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ristretto_mem_arbiter.md
RISTRETTO_MEM_ARBITER -- requirements
Module: ristretto_mem_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, data width.
REQ-002 SHALL have parameter AddressWidth, default 32, address width.
REQ-003 SHALL have parameter TimeoutCycles, default 255, maximum cycles waited for mem_valid_i; legal range 1..65535.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have port if_req_i  in  1  fetch read request.
REQ-007 SHALL have port if_addr_i  in  AddressWidth  fetch address.
REQ-008 SHALL have port if_ready_o  out  1  fetch request accepted.
REQ-009 SHALL have port if_valid_o  out  1  fetch data valid.
REQ-010 SHALL have port ld_req_i  in  1  LSU load request.
REQ-011 SHALL have port ld_addr_i  in  AddressWidth  load address.
REQ-012 SHALL have port ld_strb_i  in  DataWidth/8  load byte strobe.
REQ-013 SHALL have port ld_ready_o  out  1  load request accepted.
REQ-014 SHALL have port ld_valid_o  out  1  load data valid.
REQ-015 SHALL have port st_req_i  in  1  LSU store request.
REQ-016 SHALL have port st_addr_i  in  AddressWidth  store address.
REQ-017 SHALL have port st_strb_i  in  DataWidth/8  store byte strobe.
REQ-018 SHALL have port st_data_i  in  DataWidth  store data.
REQ-019 SHALL have port st_ready_o  out  1  store request accepted.
REQ-020 SHALL have port st_valid_o  out  1  store completed.
REQ-021 SHALL have port rdata_o  out  DataWidth  shared read data; equals mem_rdata_i.
REQ-022 SHALL have port err_o  out  1  one-cycle timeout pulse to the granted requester.
REQ-023 SHALL have port grant_o  out  2  current owner: 0 fetch, 1 load, 2 store.
REQ-024 SHALL have port busy_o  out  1  high while not IDLE.
REQ-025 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out AddressWidth, mem_strb_o out DataWidth/8, mem_wdata_o out DataWidth: unified memory request channel.
REQ-026 SHALL have ports mem_ready_i in 1, mem_valid_i in 1, mem_rdata_i in DataWidth: memory accept / response.

Function
REQ-027 SHALL implement FSM IDLE, WRDY, WVLD; one outstanding transaction.
REQ-028 IDLE: if any req_i high, SHALL select winner round-robin, starting one index after last winner (wrap 2->0); register addr, strb (fetch: all ones), wdata (store: st_data_i, else 0), we (store only), grant_o, last winner; set mem_req_o=1; go WRDY next cycle.
REQ-029 No request in IDLE: SHALL stay IDLE and hold outputs.
REQ-030 WRDY: on mem_ready_i SHALL pulse the granted ready_o combinationally same cycle, clear mem_req_o, clear timeout counter, go WVLD; otherwise hold request stable indefinitely (no timeout in WRDY).
REQ-031 WVLD: on mem_valid_i SHALL pulse the granted valid_o combinationally same cycle, go IDLE.
REQ-032 WVLD: counter increments each cycle without mem_valid_i; reaching TimeoutCycles SHALL pulse err_o one cycle, no valid_o, go IDLE.
REQ-033 Valid and timeout in same cycle: valid wins, err_o stays 0.
REQ-034 ready_o/valid_o of non-granted ports SHALL be 0; mem_ready_i/mem_valid_i in other states SHALL be ignored.
REQ-035 Arbitration only in IDLE; requests during WRDY/WVLD wait, no reordering.
REQ-036 Latency: req seen in IDLE cycle t -> mem_req_o high cycle t+1; next grant earliest one cycle after valid/err.

Reset
REQ-037 rst_i high at any point, including mid-transaction, SHALL force IDLE next edge: mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o, err_o, busy_o = 0; grant_o=0; last winner=2 (fetch wins first); counter=0; in-flight transaction dropped without ready/valid.

Verification
REQ-038 Single fetch if_addr_i=0x100, ready after 2, valid after 3 cycles -> mem_addr_o=0x100, strb=1111, we=0, if_ready_o/if_valid_o one-cycle pulses, rdata_o=mem_rdata_i.
REQ-039 if_req_i and ld_req_i asserted together after reset, held until served -> fetch granted, then load; repeat -> order alternates.
REQ-040 Store st_addr_i=0x2004, st_data_i=0xDEADBEEF, strb=0011 -> mem_we_o=1, exact values presented; st_valid_o only; ld/if outputs stay 0.
REQ-041 TimeoutCycles=4, ready given, valid withheld -> err_o pulse exactly 4 cycles after ready, back to IDLE, busy_o=0.
REQ-042 rst_i asserted in WVLD -> IDLE next cycle, all outputs reset; later mem_valid_i pulse produces no valid_o.
